exec_issue_ctrl: RTL

- Parametrised execute-stage issue/completion controller for the RV32 core; successor to the single-unit EX stage control.
- Holds the ID/EX payload register and resolves two-level operand forwarding (MEM over WB).
- Issues start pulses to NUM_FU multi-cycle functional units and joins their done handshakes, including multi-hot dispatch.
- Adds operand latching for multi-cycle ops, an exception kill mask and a completion watchdog.

---
 rtl/exec_issue_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/exec_issue_ctrl.sv
// Execute-stage issue/completion control: payload register, MEM/WB forwarding,
// start/done handshakes across NUM_FU units, kill masking and a completion watchdog.
module exec_issue_ctrl #(
    parameter int                XLEN           = 32,
    parameter int                NUM_FU         = 4,
    parameter logic [NUM_FU-1:0] KILL_MASK      = 4'b0100,
    parameter int                TIMEOUT_CYCLES = 255,
    parameter int                TO_W           = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clear,
    input  logic              valid_i,
    input  logic [NUM_FU-1:0] fu_sel_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [XLEN-1:0]   rd_data1_i,
    input  logic [XLEN-1:0]   rd_data2_i,
    input  logic              kill_i,
    input  logic [4:0]        mem_rd_i,
    input  logic              mem_wr_en_i,
    input  logic [XLEN-1:0]   mem_data_i,
    input  logic [4:0]        wb_rd_i,
    input  logic              wb_wr_en_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic [NUM_FU-1:0] fu_done_i,
    output logic              valid_o,
    output logic [NUM_FU-1:0] fu_sel_o,
    output logic [XLEN-1:0]   src1_o,
    output logic [XLEN-1:0]   src2_o,
    output logic [NUM_FU-1:0] fu_start_o,
    output logic              ex_done_o,
    output logic              busy_o,
    output logic              timeout_o,
    output logic              err_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic              valid_q;
    logic [NUM_FU-1:0] sel_q;
    logic [4:0]        rs1_q, rs2_q;
    logic [XLEN-1:0]   rd1_q, rd2_q;
    logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d;
    logic [NUM_FU-1:0] sticky_q, sticky_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   fwd1, fwd2;
    logic [NUM_FU-1:0] eff_sel, pending;

    function automatic logic [XLEN-1:0] fwd(input logic [4:0] rs,
                                            input logic [XLEN-1:0] rf);
        logic [XLEN-1:0] r;
        r = rf;
        if (rs != 5'd0) begin
            if (mem_wr_en_i && mem_rd_i == rs)     r = mem_data_i;
            else if (wb_wr_en_i && wb_rd_i == rs)  r = wb_data_i;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
        end else if (en) begin
            valid_q <= valid_i;
            sel_q   <= fu_sel_i;
            rs1_q   <= rs1_i;
            rs2_q   <= rs2_i;
            rd1_q   <= rd_data1_i;
            rd2_q   <= rd_data2_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        fwd1     = fwd(rs1_q, rd1_q);
        fwd2     = fwd(rs2_q, rd2_q);
        eff_sel  = sel_q;
        if (state_q == S_ISSUE && kill_i) eff_sel = sel_q & ~KILL_MASK;
        pending  = eff_sel & ~(sticky_q | fu_done_i);

        state_d    = state_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        sticky_d   = sticky_q | (fu_done_i & sel_q);
        cnt_d      = cnt_q;
        err_d      = err_q;
        fu_start_o = '0;
        ex_done_o  = 1'b0;
        busy_o     = 1'b0;
        timeout_o  = 1'b0;

        unique case (state_q)
            S_IDLE: ex_done_o = 1'b1;
            S_ISSUE: begin
                busy_o     = 1'b1;
                fu_start_o = eff_sel;
                op1_d      = fwd1;
                op2_d      = fwd2;
                // killed units never start, so count them as finished
                sticky_d   = sticky_d | (sel_q & ~eff_sel);
                if (pending == '0) begin
                    ex_done_o = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                busy_o = 1'b1;
                if (pending == '0) begin
                    ex_done_o = 1'b1;
                    state_d   = S_DONE;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                    timeout_o = 1'b1;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_DONE: ex_done_o = 1'b1;
            default: ex_done_o = 1'b1;
        endcase

        if (clear || en) begin
            state_d  = (!clear && valid_i && fu_sel_i != '0) ? S_ISSUE : S_IDLE;
            sticky_d = '0;
            cnt_d    = '0;
            err_d    = 1'b0;
        end
    end

    assign valid_o  = valid_q;
    assign fu_sel_o = sel_q;
    assign err_o    = err_q;
    assign src1_o   = (state_q == S_WAIT || state_q == S_DONE) ? op1_q : fwd1;
    assign src2_o   = (state_q == S_WAIT || state_q == S_DONE) ? op2_q : fwd2;

endmodule
